// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding read per fetch, with flush,
// bus-error and response-timeout handling.
module ifetch_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_done,
  output logic        fetch_busy,
  output logic        fault_valid,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] addr;
  logic [7:0]  cnt;

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = addr;
  assign fetch_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      instr_out   <= 32'h0000_0013;
      instr_pc    <= 32'h8000_0000;
      fetch_done  <= 1'b0;
      fault_valid <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      fetch_done  <= 1'b0;
      fault_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_start && !flush) begin
            if (pc_in[1:0] != 2'b00) begin
              fault_valid <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              addr  <= pc_in;
              state <= REQ;
            end
          end
        end
        REQ: begin
          // An accepted request still owes us a response, so a flush
          // racing the handshake must drain it.
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (!flush) begin
              if (mem_rsp_err) begin
                fault_valid <= 1'b1;
                fault_cause <= 2'b10;
              end else begin
                instr_out  <= mem_rsp_data;
                instr_pc   <= addr;
                fetch_done <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (flush) begin
              state <= DRAIN;
            end else if (cnt == TO_LAST) begin
              fault_valid <= 1'b1;
              fault_cause <= 2'b11;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (mem_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
